irq_pending_ctrl: RTL

Interrupt-request front end for the priority-encode path. It captures eight asynchronous-to-the-consumer request lines into a pending register, applies a mask and in-service nesting rules, and presents the highest-priority eligible request as a stable one-hot vector plus 3-bit index under a valid/ack handshake. A downstream consumer acknowledges the request and later signals end-of-interrupt (EOI).

---
 rtl/irq_pkg.sv | 30 +++
 rtl/prio_enc8.sv | 18 +
 rtl/irq_pending_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt pending/presentation front end.
package irq_pkg;

    localparam int N_IRQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } prio_t;

    // Scans upward so the last hit, i.e. the highest set bit, wins.
    function automatic prio_t highest_set(input logic [N_IRQ-1:0] vec);
        prio_t res;
        res = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (vec[i]) begin
                res.found = 1'b1;
                res.idx   = IDX_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder; bit 7 has the highest priority.
module prio_enc8
    import irq_pkg::*;
(
    input  logic [N_IRQ-1:0] vec,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    prio_t res;

    always_comb begin
        res   = highest_set(vec);
        valid = res.found;
        idx   = res.idx;
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Latches request lines into a pending register and presents the highest
// eligible request, honouring the mask and in-service nesting.
module irq_pending_ctrl #(
    parameter int EDGE_MODE = 1,
    parameter int N_IRQ     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq_in,
    input  logic [7:0] mask_in,
    output logic       req_valid,
    output logic [2:0] req_idx,
    output logic [7:0] req_onehot,
    input  logic       req_ack,
    input  logic       eoi,
    output logic [7:0] pending,
    output logic [7:0] in_service
);

    import irq_pkg::*;

    if (N_IRQ != 8) begin : g_bad_width
        $error("irq_pending_ctrl supports exactly 8 request lines");
    end

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_next;
    logic [7:0]       irq_q;
    logic [7:0]       pending_next;
    logic [7:0]       in_service_next;

    logic [7:0]       set_vec;
    logic [7:0]       eligible;
    logic [7:0]       clr_vec;
    logic [7:0]       grant_vec;
    logic [7:0]       eoi_vec;
    logic             cand_valid;
    logic [IDX_W-1:0] cand_idx;
    logic             isr_valid;
    logic [IDX_W-1:0] isr_idx;
    logic             presentable;

    assign set_vec  = (EDGE_MODE != 0) ? (irq_in & ~irq_q) : irq_in;
    assign eligible = pending & ~mask_in;

    prio_enc8 u_enc_elig (
        .vec   (eligible),
        .valid (cand_valid),
        .idx   (cand_idx)
    );

    prio_enc8 u_enc_isr (
        .vec   (in_service),
        .valid (isr_valid),
        .idx   (isr_idx)
    );

    // Only the top eligible candidate matters: if it cannot preempt the
    // current in-service level, no lower candidate can either.
    assign presentable = cand_valid && (!isr_valid || (cand_idx > isr_idx));

    // Handshake: req_valid/req_idx are held stable from presentation until
    // the cycle req_ack is high; that cycle completes the transfer, and
    // req_ack outside a presentation has no effect.
    always_comb begin
        state_next = state;
        idx_next   = idx_r;
        clr_vec    = '0;
        grant_vec  = '0;
        case (state)
            IDLE: begin
                if (presentable) begin
                    idx_next   = cand_idx;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (req_ack) begin
                    clr_vec    = 8'b0000_0001 << idx_r;
                    grant_vec  = 8'b0000_0001 << idx_r;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        eoi_vec         = (eoi && isr_valid) ? (8'b0000_0001 << isr_idx) : 8'b0;
        // A new set condition overrides the ack's clear of the same bit.
        pending_next    = (pending & ~clr_vec) | set_vec;
        in_service_next = (in_service & ~eoi_vec) | grant_vec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx_r      <= '0;
            irq_q      <= '0;
            pending    <= '0;
            in_service <= '0;
        end else begin
            state      <= state_next;
            idx_r      <= idx_next;
            irq_q      <= irq_in;
            pending    <= pending_next;
            in_service <= in_service_next;
        end
    end

    assign req_valid  = (state == PRESENT);
    assign req_idx    = req_valid ? idx_r : '0;
    assign req_onehot = req_valid ? (8'b0000_0001 << idx_r) : 8'b0;

endmodule
